// File: rtl/task_scheduler.sv
// Task scheduler: walks a flat task program, broadcasts instruction streams and R0
// seeds to a core subset, waits for completion and optionally runs a VGA frame copy.
module task_scheduler #(
  parameter int NUM_OF_CORES = 4,
  parameter int REG_SIZE     = 8,
  parameter int INSN_SIZE    = 16,
  parameter int TM_WORDS     = 256,
  parameter int LC_SIZE      = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [TM_WORDS*INSN_SIZE-1:0]    env_task_memory,
  input  logic [NUM_OF_CORES-1:0]          Ready,
  output logic [NUM_OF_CORES-1:0]          Start,
  output logic [LC_SIZE-1:0]               Insn_Load_Counter,
  output logic [INSN_SIZE-1:0]             Insn_Data,
  output logic [NUM_OF_CORES-1:0]          Init_R0_Vect,
  output logic [NUM_OF_CORES*REG_SIZE-1:0] Init_R0,
  output logic                             vga_en,
  input  logic                             vga_end
);

  // Pointer arithmetic wraps naturally in PW bits (TM_WORDS is a power of two).
  localparam int PW       = $clog2(TM_WORDS);
  localparam int R0_BITS  = NUM_OF_CORES * REG_SIZE;
  localparam int R0_WORDS = R0_BITS / INSN_SIZE;
  localparam int HDR_STOP = 15;
  localparam int HDR_VGA  = 14;
  localparam int HDR_INIT = 13;

  typedef enum logic [3:0] {
    S_DECODE, S_PRELOAD, S_LOAD, S_GUARD, S_WAIT,
    S_VGA_CHK, S_VGA_WAIT, S_ADVANCE, S_HALT
  } state_t;

  state_t                  r_state, w_state_next;
  logic [PW-1:0]           r_ptr;
  logic [NUM_OF_CORES-1:0] r_mask;
  logic                    r_init;
  logic                    r_vga;
  logic [LC_SIZE-1:0]      r_n;
  logic [R0_BITS-1:0]      r_r0;
  logic [LC_SIZE-1:0]      r_k, w_k_next;
  logic                    r_guard;

  logic [NUM_OF_CORES-1:0] r_start;
  logic [LC_SIZE-1:0]      r_lc;
  logic [INSN_SIZE-1:0]    r_data;
  logic [NUM_OF_CORES-1:0] r_vect;
  logic [R0_BITS-1:0]      r_r0_out;
  logic                    r_vga_en;

  logic [INSN_SIZE-1:0]    w_mem [TM_WORDS];
  logic [R0_BITS-1:0]      w_r0;
  logic [LC_SIZE-1:0]      w_n;
  logic [NUM_OF_CORES-1:0] w_hdr_mask;
  logic [PW-1:0]           w_insn_base;
  logic [PW-1:0]           w_insn_addr;
  logic                    w_loading;
  logic                    w_mask_ready;

  genvar gi;
  generate
    for (gi = 0; gi < TM_WORDS; gi++) begin : g_mem
      assign w_mem[gi] = env_task_memory[gi*INSN_SIZE +: INSN_SIZE];
    end
    for (gi = 0; gi < R0_WORDS; gi++) begin : g_r0
      assign w_r0[gi*INSN_SIZE +: INSN_SIZE] = w_mem[r_ptr + PW'(gi + 2)];
    end
  endgenerate

  assign w_hdr_mask   = w_mem[r_ptr][NUM_OF_CORES-1:0];
  assign w_n          = w_mem[r_ptr + PW'(1)][LC_SIZE-1:0];
  assign w_mask_ready = ((Ready & r_mask) == r_mask);
  assign w_insn_base  = r_ptr + PW'(2) + (r_init ? PW'(R0_WORDS) : PW'(0));
  assign w_insn_addr  = w_insn_base + PW'(w_k_next);
  assign w_loading    = (w_state_next == S_LOAD);

  always_comb begin
    w_state_next = r_state;
    w_k_next     = '0;
    case (r_state)
      S_DECODE: begin
        if (w_mem[r_ptr][HDR_STOP])
          w_state_next = S_HALT;
        else if (w_hdr_mask == '0 || w_n == '0)
          w_state_next = S_VGA_CHK;
        else
          w_state_next = S_PRELOAD;
      end
      S_PRELOAD: if (w_mask_ready) w_state_next = S_LOAD;
      S_LOAD: begin
        if (r_k == r_n - LC_SIZE'(1))
          w_state_next = S_GUARD;
        else
          w_k_next = r_k + LC_SIZE'(1);
      end
      S_GUARD:    if (r_guard) w_state_next = S_WAIT;
      S_WAIT:     if (w_mask_ready) w_state_next = S_VGA_CHK;
      S_VGA_CHK:  w_state_next = r_vga ? S_VGA_WAIT : S_ADVANCE;
      S_VGA_WAIT: if (vga_end) w_state_next = S_ADVANCE;
      S_ADVANCE:  w_state_next = S_DECODE;
      S_HALT:     w_state_next = S_HALT;
      default:    w_state_next = S_DECODE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_DECODE;
      r_ptr    <= '0;
      r_mask   <= '0;
      r_init   <= 1'b0;
      r_vga    <= 1'b0;
      r_n      <= '0;
      r_r0     <= '0;
      r_k      <= '0;
      r_guard  <= 1'b0;
      r_start  <= '0;
      r_lc     <= '0;
      r_data   <= '0;
      r_vect   <= '0;
      r_r0_out <= '0;
      r_vga_en <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_k     <= w_k_next;
      r_guard <= (r_state == S_GUARD) && !r_guard;
      if (r_state == S_DECODE) begin
        r_mask <= w_hdr_mask;
        r_init <= w_mem[r_ptr][HDR_INIT];
        r_vga  <= w_mem[r_ptr][HDR_VGA];
        r_n    <= w_n;
        // R0 words only exist in the record when INIT_R0 is set.
        r_r0   <= w_mem[r_ptr][HDR_INIT] ? w_r0 : '0;
      end
      if (r_state == S_ADVANCE)
        r_ptr <= w_insn_base + PW'(r_n);
      // Outputs are registered images of the state being entered.
      r_start  <= w_loading ? r_mask : '0;
      r_lc     <= w_loading ? w_k_next : '0;
      r_data   <= w_loading ? w_mem[w_insn_addr] : '0;
      r_vect   <= (w_loading && r_init) ? r_mask : '0;
      r_r0_out <= w_loading ? r_r0 : '0;
      r_vga_en <= (w_state_next == S_VGA_WAIT);
    end
  end

  assign Start             = r_start;
  assign Insn_Load_Counter = r_lc;
  assign Insn_Data         = r_data;
  assign Init_R0_Vect      = r_vect;
  assign Init_R0           = r_r0_out;
  assign vga_en            = r_vga_en;

endmodule

// File: tb/tb_task_scheduler.sv
// Bench for task_scheduler: models cores and the VGA copy engine, compares every
// load burst and handshake against an event list derived from the task program.
`timescale 1ns/1ps
module tb_task_scheduler;
  localparam int NC = 4, RS = 8, IW = 16, TM = 256, LC = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  wire  [TM*IW-1:0] tm;
  logic [IW-1:0]    mem [TM];
  logic [NC-1:0]    ready = '1;
  logic [NC-1:0]    start, r0_vect;
  logic [LC-1:0]    lc;
  logic [IW-1:0]    data;
  logic [NC*RS-1:0] r0;
  logic             vga_en;
  logic             vga_end = 1'b0;
  int checks = 0, failures = 0;

  typedef struct {
    bit            is_vga;
    logic [NC-1:0] mask;
    logic [NC-1:0] vect;
    logic [NC*RS-1:0] r0v;
    int            n;
    int            base;
  } ev_t;
  ev_t exp_q[$];

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < TM; gi++) begin : g_pack
      assign tm[gi*IW +: IW] = mem[gi];
    end
  endgenerate

  task_scheduler #(.NUM_OF_CORES(NC), .REG_SIZE(RS), .INSN_SIZE(IW), .TM_WORDS(TM), .LC_SIZE(LC)) dut (
    .clk(clk), .reset(reset), .env_task_memory(tm), .Ready(ready), .Start(start),
    .Insn_Load_Counter(lc), .Insn_Data(data), .Init_R0_Vect(r0_vect), .Init_R0(r0),
    .vga_en(vga_en), .vga_end(vga_end));

  // Walk the program record by record and list the observable events it must produce.
  task automatic build_model();
    int p, n, off;
    logic [IW-1:0] h;
    ev_t e;
    p = 0;
    exp_q.delete();
    for (int rec = 0; rec < 80; rec++) begin
      h = mem[p];
      if (h[15]) break;
      n = int'(mem[(p+1)%TM][LC-1:0]);
      off = h[13] ? 2 : 0;
      if (h[3:0] != 4'd0 && n != 0) begin
        e.is_vga = 1'b0;
        e.mask   = h[3:0];
        e.vect   = h[13] ? h[3:0] : 4'd0;
        e.r0v    = h[13] ? {mem[(p+3)%TM], mem[(p+2)%TM]} : 32'd0;
        e.n      = n;
        e.base   = (p + 2 + off) % TM;
        exp_q.push_back(e);
      end
      if (h[14]) begin
        e.is_vga = 1'b1; e.mask = '0; e.vect = '0; e.r0v = '0; e.n = 0; e.base = 0;
        exp_q.push_back(e);
      end
      p = (p + 2 + off + n) % TM;
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < TM; i++) mem[i] = 16'($urandom);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_program(input string name, input bit do_reset, input int busy_fix,
                             input int vga_fix, input bit spont, input int budget);
    int busy [NC];
    ev_t cur;
    bit in_burst, vga_active, prev_done, prev_vga, end_seen, finished, abort;
    logic [NC-1:0] seen, prev_start, pending;
    int k, vga_cnt, idle_cnt, cyc;
    in_burst = 0; vga_active = 0; prev_done = 1; prev_vga = 0; finished = 0; abort = 0;
    prev_start = '0; pending = '0; k = 0; vga_cnt = 0; idle_cnt = 0; cyc = 0;
    cur.is_vga = 0; cur.mask = '0; cur.vect = '0; cur.r0v = '0; cur.n = 0; cur.base = 0;
    for (int i = 0; i < NC; i++) busy[i] = 0;
    ready = '1;
    vga_end = 1'b0;
    if (do_reset) apply_reset();
    while (!finished && !abort && cyc < budget) begin
      @(negedge clk);
      cyc++;
      seen = ready;
      end_seen = vga_end;
      if (start != '0 && !in_burst) begin
        checks++;
        if (exp_q.size() == 0 || exp_q[0].is_vga) begin
          failures++;
          $display("FAIL %s unexpected_load: start=%b pending_events=%0d", name, start, exp_q.size());
          abort = 1;
        end else begin
          cur = exp_q.pop_front();
          in_burst = 1;
          k = 0;
          checks++;
          if (!prev_done || vga_active) begin
            failures++;
            $display("FAIL %s serialize: load began with previous task busy (cores_done=%0d vga_busy=%0d)", name, prev_done, vga_active);
          end
          checks++;
          if ((seen & cur.mask) !== cur.mask) begin
            failures++;
            $display("FAIL %s preload: Ready=%b when load began, need all of %b", name, seen, cur.mask);
          end
        end
      end
      if (in_burst && start != '0) begin
        checks++;
        if (start !== cur.mask || lc !== LC'(k) || data !== mem[(cur.base+k)%TM] ||
            r0_vect !== cur.vect || r0 !== cur.r0v) begin
          failures++;
          $display("FAIL %s load_cycle k=%0d: got start=%b lc=%0d data=%h vect=%b r0=%h, want start=%b lc=%0d data=%h vect=%b r0=%h",
                   name, k, start, lc, data, r0_vect, r0, cur.mask, k, mem[(cur.base+k)%TM], cur.vect, cur.r0v);
        end
        k++;
      end else if (in_burst) begin
        checks++;
        if (k != cur.n) begin
          failures++;
          $display("FAIL %s burst_len: got %0d cycles, want %0d", name, k, cur.n);
        end
        in_burst = 0;
        pending = cur.mask;
        prev_done = 0;
      end
      if (start == '0) begin
        checks++;
        if (lc !== '0 || r0_vect !== '0 || r0 !== '0) begin
          failures++;
          $display("FAIL %s idle_outputs: lc=%0d vect=%b r0=%h, want all 0", name, lc, r0_vect, r0);
        end
      end
      if (vga_en && !prev_vga) begin
        checks++;
        if (exp_q.size() == 0 || !exp_q[0].is_vga || in_burst || !prev_done) begin
          failures++;
          $display("FAIL %s unexpected_vga: pending_events=%0d cores_done=%0d", name, exp_q.size(), prev_done);
          abort = 1;
        end else begin
          void'(exp_q.pop_front());
          vga_active = 1;
          vga_cnt = (vga_fix != 0) ? vga_fix : $urandom_range(1, 25);
        end
      end
      if (prev_vga) begin
        checks++;
        if (end_seen && vga_en !== 1'b0) begin
          failures++;
          $display("FAIL %s vga_release: vga_en=%b after vga_end, want 0", name, vga_en);
        end else if (!end_seen && vga_en !== 1'b1) begin
          failures++;
          $display("FAIL %s vga_hold: vga_en=%b before vga_end, want 1", name, vga_en);
        end
        if (end_seen) vga_active = 0;
      end
      vga_end = 1'b0;
      if (vga_active && vga_en) begin
        if (vga_cnt > 0) vga_cnt--;
        if (vga_cnt == 0) vga_end = 1'b1;
      end else if (!vga_en && spont && $urandom_range(0, 19) == 0) begin
        vga_end = 1'b1;
      end
      for (int i = 0; i < NC; i++) begin
        if (prev_start[i] && !start[i])
          busy[i] = (busy_fix != 0) ? busy_fix : $urandom_range(1, 12);
        else if (busy[i] > 0)
          busy[i]--;
        else if (spont && start == '0 && $urandom_range(0, 31) == 0)
          busy[i] = $urandom_range(1, 6);
        ready[i] = (busy[i] == 0);
      end
      if (!prev_done) begin
        prev_done = 1;
        for (int i = 0; i < NC; i++) if (pending[i] && busy[i] != 0) prev_done = 0;
      end
      if (exp_q.size() == 0 && !in_burst && !vga_active) idle_cnt++;
      else idle_cnt = 0;
      if (idle_cnt >= 40) finished = 1;
      prev_start = start;
      prev_vga = vga_en;
    end
    if (!finished && !abort) begin
      checks++;
      failures++;
      $display("FAIL %s timeout: %0d events still pending after %0d cycles", name, exp_q.size(), cyc);
    end
    checks++;
    if (start !== '0 || vga_en !== 1'b0) begin
      failures++;
      $display("FAIL %s halt: start=%b vga_en=%b, want 0", name, start, vga_en);
    end
    $display("run %s: cycles=%0d checks=%0d failures=%0d", name, cyc, checks, failures);
  endtask

  task automatic test_reset();
    fill_random();
    reset = 1'b1;
    #1;
    checks++;
    if (start !== '0 || lc !== '0 || data !== '0 || r0_vect !== '0 || r0 !== '0 || vga_en !== 1'b0) begin
      failures++;
      $display("FAIL reset_async: start=%b lc=%0d data=%h vect=%b r0=%h vga_en=%b", start, lc, data, r0_vect, r0, vga_en);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (start !== '0 || lc !== '0 || data !== '0 || r0_vect !== '0 || r0 !== '0 || vga_en !== 1'b0) begin
      failures++;
      $display("FAIL reset_held: start=%b lc=%0d data=%h vect=%b r0=%h vga_en=%b", start, lc, data, r0_vect, r0, vga_en);
    end
    reset = 1'b0;
  endtask

  task automatic test_directed();
    fill_random();
    mem[0] = 16'h0003; mem[1] = 16'h0002; mem[2] = 16'hA001; mem[3] = 16'hA002;
    mem[4] = 16'h2005; mem[5] = 16'h0001; mem[6] = 16'h2211; mem[7] = 16'h4433; mem[8] = 16'hB001;
    mem[9] = 16'h4001; mem[10] = 16'h0001; mem[11] = 16'hC001;
    mem[12] = 16'h8000;
    build_model();
    run_program("directed", 1'b1, 10, 20, 1'b0, 2000);
  endtask

  task automatic test_stop_at_zero();
    fill_random();
    mem[0] = 16'hFFFF;
    build_model();
    run_program("stop_at_zero", 1'b1, 0, 0, 1'b1, 500);
  endtask

  task automatic test_wrap();
    fill_random();
    mem[0] = 16'h1003; mem[1] = 16'h0004; mem[4] = 16'h8000;
    mem[6] = 16'h0000; mem[7] = 16'h00F7;
    mem[255] = 16'h0004;
    build_model();
    run_program("wrap", 1'b1, 0, 0, 1'b0, 2000);
  endtask

  task automatic test_reset_mid_load();
    int waited;
    fill_random();
    mem[0] = 16'h000F; mem[1] = 16'h0014; mem[22] = 16'h8000;
    build_model();
    ready = '1;
    vga_end = 1'b0;
    apply_reset();
    waited = 0;
    while (start == '0 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (start !== 4'hF) begin
      failures++;
      $display("FAIL midload_start: start=%b, want 1111", start);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (lc !== 8'd5) begin
      failures++;
      $display("FAIL midload_counter: lc=%0d, want 5", lc);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (start !== '0 || lc !== '0 || r0_vect !== '0 || vga_en !== 1'b0) begin
      failures++;
      $display("FAIL midload_reset: start=%b lc=%0d vect=%b vga_en=%b, want 0", start, lc, r0_vect, vga_en);
    end
    @(negedge clk);
    reset = 1'b0;
    run_program("midload_restart", 1'b0, 0, 0, 1'b0, 2000);
  endtask

  task automatic test_random(input int iter);
    int p, n;
    logic [3:0] m;
    bit init, vga;
    fill_random();
    p = 0;
    while (p < 225) begin
      m    = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      n    = $urandom_range(0, 6);
      init = 1'($urandom_range(0, 1));
      vga  = ($urandom_range(0, 3) == 0);
      mem[p]   = {1'b0, vga, init, 9'($urandom), m};
      mem[p+1] = {8'($urandom), 8'(n)};
      p = p + 2 + (init ? 2 : 0) + n;
    end
    mem[p] = 16'h8000 | 16'($urandom_range(0, 32767));
    build_model();
    run_program($sformatf("random%0d", iter), 1'b1, 0, 0, 1'b1, 20000);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stop_at_zero();
    test_wrap();
    test_reset_mid_load();
    for (int it = 0; it < 4; it++) test_random(it);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
